alu_seq: RTL

- Parametrised, registered successor to the datapath ALU.
- Adds configurable WIDTH, an extended op set (OR, XOR, shifts) and a multi-cycle iterative multiply.
- Uses a start/busy/done handshake; result and status flags are registered.
- Sits between the register-file operand latches and the writeback mux. The controller FSM issues start and waits for done before writeback.

---
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// alu_seq request/response bundle.
// Controller drives the request side, the ALU answers.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       ALUop;
  logic [WIDTH-1:0] Ain;
  logic [WIDTH-1:0] Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic [2:0]       Z;

  modport master (
    output start, ALUop, Ain, Bin,
    input  busy, done, out, Z
  );

  modport slave (
    input  start, ALUop, Ain, Bin,
    output busy, done, out, Z
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake.
// Single-cycle logic ops plus a shift-add iterative multiply.
module alu_seq #(
  parameter  int WIDTH = 16,
  localparam int SH_W  = $clog2(WIDTH)
) (
  input logic clk,
  input logic reset,
  alu_seq_if.slave bus
);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHF = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [SH_W:0] CNT_LAST = (SH_W+1)'(WIDTH);
  localparam logic [SH_W:0] CNT_ONE  = (SH_W+1)'(1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplr_q;
  logic [WIDTH:0]   acc_q;
  logic             lost_q;
  logic [SH_W:0]    cnt_q;

  logic [WIDTH-1:0] out_q, out_d;
  logic [2:0]       z_q, z_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] res;
  logic             ovf;
  logic [SH_W-1:0]  amt;
  logic [WIDTH:0]   add;
  logic [WIDTH:0]   acc_n;
  logic [SH_W:0]    cnt_n;
  logic             last;
  logic             accept;
  logic             go_mul;

  assign accept = bus.start && (state_q == IDLE);
  assign go_mul = accept && (bus.ALUop == OP_MUL);
  assign amt    = bus.Bin[SH_W-1:0];

  // Single-cycle result and signed overflow
  always_comb begin
    res = '0;
    ovf = 1'b0;
    unique case (bus.ALUop)
      OP_ADD: begin
        res = bus.Ain + bus.Bin;
        ovf = (bus.Ain[WIDTH-1] == bus.Bin[WIDTH-1]) &&
              (res[WIDTH-1] != bus.Ain[WIDTH-1]);
      end
      OP_SUB: begin
        res = bus.Ain - bus.Bin;
        ovf = (bus.Ain[WIDTH-1] != bus.Bin[WIDTH-1]) &&
              (res[WIDTH-1] != bus.Ain[WIDTH-1]);
      end
      OP_AND: res = bus.Ain & bus.Bin;
      OP_NOT: res = ~bus.Bin;
      OP_OR:  res = bus.Ain | bus.Bin;
      OP_XOR: res = bus.Ain ^ bus.Bin;
      OP_SHF: begin
        if (bus.Bin[WIDTH-1])
          res = WIDTH'($signed(bus.Ain) >>> amt);
        else if (bus.Bin[WIDTH-2])
          res = bus.Ain >> amt;
        else
          res = bus.Ain << amt;
      end
      OP_MUL: res = '0;
    endcase
  end

  // One shift-add step; bit WIDTH of acc is a sticky overflow
  always_comb begin
    add = {1'b0, acc_q[WIDTH-1:0]};
    if (mplr_q[0])
      add = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, mcand_q};
    acc_n = {acc_q[WIDTH] | add[WIDTH] |
             (mplr_q[0] & lost_q),
             add[WIDTH-1:0]};
    cnt_n = cnt_q + CNT_ONE;
    last  = (cnt_n == CNT_LAST);
  end

  // Next state and registered-output load values
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    z_d     = z_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.ALUop == OP_MUL) begin
            state_d = MUL;
          end else begin
            out_d  = res;
            z_d    = {ovf, res[WIDTH-1], ~|res};
            done_d = 1'b1;
          end
        end
      end
      MUL: begin
        if (last) begin
          state_d = IDLE;
          out_d   = acc_n[WIDTH-1:0];
          z_d     = {acc_n[WIDTH],
                     acc_n[WIDTH-1],
                     ~|acc_n[WIDTH-1:0]};
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      out_q   <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      z_q     <= z_d;
      done_q  <= done_d;
    end
  end

  // Multiplier datapath: load on accept, step while in MUL
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      lost_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (go_mul) begin
      mcand_q <= bus.Ain;
      mplr_q  <= bus.Bin;
      acc_q   <= '0;
      lost_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (state_q == MUL) begin
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      acc_q   <= acc_n;
      lost_q  <= lost_q | mcand_q[WIDTH-1];
      cnt_q   <= cnt_n;
    end
  end

  assign bus.busy = (state_q == MUL);
  assign bus.done = done_q;
  assign bus.out  = out_q;
  assign bus.Z    = z_q;

endmodule
